// File: rtl/vic_pkg.sv
// Shared definitions for the VIC pixel-side shifter.
// Holds the cell phase constants, the cell width, the bit fields of the
// colour PROM entry, and the packed fg/bg colour pair used between the
// fetch stage and the serializer.
package vic_pkg;

    localparam int CELL_W = 8;

    // Values of hcnt[2:0] at which each fetch step happens within a cell.
    localparam logic [2:0] PH_CODE = 3'd2;
    localparam logic [2:0] PH_PAT  = 3'd5;
    localparam logic [2:0] PH_LOAD = 3'd7;

    // Colour PROM byte layout: [7:5] foreground RGB, [3:1] background RGB.
    localparam int PROM_FG_MSB = 7;
    localparam int PROM_FG_LSB = 5;
    localparam int PROM_BG_MSB = 3;
    localparam int PROM_BG_LSB = 1;

    typedef struct packed {
        logic [2:0] fg;
        logic [2:0] bg;
    } colour_t;

endpackage

// File: rtl/vic_pix_serializer.sv
// Per-cell pixel serializer.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   ce_pix          pixel clock enable
//   load            parallel load of pattern/colour (phase 7)
//   flip            shift direction, captured only on load
//   pattern         8-bit pattern row to serialise
//   colour_in       fg/bg pair for the cell being loaded
//   pix_bit         current pixel bit
//   colour_sh       fg/bg pair of the cell currently being shifted out
module vic_pix_serializer
    import vic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic              load,
    input  logic              flip,
    input  logic [CELL_W-1:0] pattern,
    input  colour_t           colour_in,
    output logic              pix_bit,
    output colour_t           colour_sh
);

    logic [CELL_W-1:0] shift_reg;
    logic              flip_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            colour_sh <= '0;
            flip_q    <= 1'b0;
        end else if (ce_pix) begin
            if (load) begin
                shift_reg <= pattern;
                colour_sh <= colour_in;
                flip_q    <= flip;
            end else if (flip_q) begin
                shift_reg <= {1'b0, shift_reg[CELL_W-1:1]};
            end else begin
                shift_reg <= {shift_reg[CELL_W-2:0], 1'b0};
            end
        end
    end

    // Direction is latched with the data so a flip change mid-cell
    // cannot tear the cell currently on screen.
    assign pix_bit = flip_q ? shift_reg[0] : shift_reg[CELL_W-1];

endmodule

// File: rtl/vic_video_shifter.sv
// VIC video shifter: latches tile code, pattern row and colour PROM entry
// for each 8-pixel cell, serialises the pattern and drives blanked RGB.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   ce_pix                pixel clock enable
//   hcnt, vcnt            beam counters from the timing block
//   hblank, vblank        blanking from the timing block
//   vram_data             screen RAM data (tile code)
//   cram_data             character RAM data (pattern row)
//   palette               palette bank select
//   flip                  cocktail flip
//   cram_addr             character RAM address {tile code, row}
//   prom_addr             colour PROM address {palette, tile code[7:5]}
//   prom_data             colour PROM data
//   rgb                   pixel colour
//   pix_blank             blank aligned with rgb
module vic_video_shifter
    import vic_pkg::*;
#(
    parameter int PAL_W   = 2,
    parameter bit FLIP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [8:0]       hcnt,
    input  logic [8:0]       vcnt,
    input  logic             hblank,
    input  logic             vblank,
    input  logic [7:0]       vram_data,
    input  logic [7:0]       cram_data,
    input  logic [PAL_W-1:0] palette,
    input  logic             flip,
    output logic [10:0]      cram_addr,
    output logic [PAL_W+2:0] prom_addr,
    input  logic [7:0]       prom_data,
    output logic [2:0]       rgb,
    output logic             pix_blank
);

    logic [2:0]        phase;
    logic              flip_i;
    logic [2:0]        row;
    logic [7:0]        tile_code_q;
    logic [CELL_W-1:0] pattern_q;
    colour_t           colour_q;
    colour_t           colour_sh;
    logic              pix_bit;
    logic [CELL_W-1:0] blank_line;
    logic              blank_d;
    logic              unused_bits;

    assign phase  = hcnt[2:0];
    assign flip_i = FLIP_EN & flip;
    assign row    = flip_i ? ~vcnt[2:0] : vcnt[2:0];

    assign cram_addr = {tile_code_q, row};
    assign prom_addr = {palette, tile_code_q[7:5]};

    assign unused_bits = &{1'b0, hcnt[8:3], vcnt[8:3], prom_data[4], prom_data[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            tile_code_q <= '0;
            pattern_q   <= '0;
            colour_q    <= '0;
        end else if (ce_pix) begin
            if (phase == PH_CODE) begin
                tile_code_q <= vram_data;
            end
            if (phase == PH_PAT) begin
                pattern_q   <= cram_data;
                colour_q.fg <= prom_data[PROM_FG_MSB:PROM_FG_LSB];
                colour_q.bg <= prom_data[PROM_BG_MSB:PROM_BG_LSB];
            end
        end
    end

    vic_pix_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .load      (phase == PH_LOAD),
        .flip      (flip_i),
        .pattern   (pattern_q),
        .colour_in (colour_q),
        .pix_bit   (pix_bit),
        .colour_sh (colour_sh)
    );

    // Eight-deep delay matches the fetch-to-pixel pipeline so blanking
    // lines up with the cell it belongs to. Resets to blanked.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_line <= '1;
        end else if (ce_pix) begin
            blank_line <= {blank_line[CELL_W-2:0], hblank | vblank};
        end
    end

    assign blank_d = blank_line[CELL_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb       <= 3'b000;
            pix_blank <= 1'b1;
        end else if (ce_pix) begin
            rgb       <= blank_d ? 3'b000 : (pix_bit ? colour_sh.fg : colour_sh.bg);
            pix_blank <= blank_d;
        end
    end

endmodule

// File: tb/tb_vic_video_shifter.sv
module tb_vic_video_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic [8:0]  hcnt;
    logic [8:0]  vcnt;
    logic        hblank;
    logic        vblank;
    logic [7:0]  vram_data;
    logic [7:0]  cram_data;
    logic [1:0]  palette;
    logic        flip;
    logic [10:0] cram_addr;
    logic [4:0]  prom_addr;
    logic [7:0]  prom_data;
    logic [2:0]  rgb;
    logic        pix_blank;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vic_video_shifter #(.PAL_W(2), .FLIP_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hblank    (hblank),
        .vblank    (vblank),
        .vram_data (vram_data),
        .cram_data (cram_data),
        .palette   (palette),
        .flip      (flip),
        .cram_addr (cram_addr),
        .prom_addr (prom_addr),
        .prom_data (prom_data),
        .rgb       (rgb),
        .pix_blank (pix_blank)
    );

    typedef struct packed {
        logic [7:0]  vram;
        logic [7:0]  cram;
        logic [7:0]  prom;
        logic        flp;
        logic [8:0]  vc;
        logic [1:0]  pal;
        logic [10:0] exp_cram;
        logic [4:0]  exp_prom;
        logic [23:0] exp_rgb;   // pixel 0 in [23:21]
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (hcnt=%0d)", name, got, exp, hcnt);
        end
    endtask

    // One ce_pix pulse every other clk; hcnt advances after each pulse.
    task automatic step();
        @(negedge clk);
        ce_pix = 1'b1;
        @(posedge clk);
        #1;
        ce_pix = 1'b0;
        hcnt = (hcnt == 9'd327) ? 9'd0 : hcnt + 9'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        vram_data = v.vram;
        cram_data = v.cram;
        prom_data = v.prom;
        flip      = v.flp;
        vcnt      = v.vc;
        palette   = v.pal;
    endtask

    function automatic vec_t mk(input logic [7:0] vr, input logic [7:0] cr,
                                input logic [7:0] pr, input logic fl,
                                input logic [8:0] vc, input logic [1:0] pal,
                                input logic [10:0] ec, input logic [4:0] ep,
                                input logic [23:0] er);
        vec_t v;
        v.vram = vr; v.cram = cr; v.prom = pr; v.flp = fl; v.vc = vc;
        v.pal = pal; v.exp_cram = ec; v.exp_prom = ep; v.exp_rgb = er;
        return v;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] px;
        int n;

        vecs[0] = mk(8'h41, 8'hA5, 8'hE2, 1'b0, 9'd0, 2'd0, 11'h208, 5'h02,
                     {3'd7,3'd1,3'd7,3'd1,3'd1,3'd7,3'd1,3'd7});
        vecs[1] = mk(8'h41, 8'hA5, 8'hE2, 1'b1, 9'd3, 2'd0, 11'h20C, 5'h02,
                     {3'd7,3'd1,3'd7,3'd1,3'd1,3'd7,3'd1,3'd7});
        vecs[2] = mk(8'h41, 8'h81, 8'hE2, 1'b1, 9'd3, 2'd0, 11'h20C, 5'h02,
                     {3'd7,3'd1,3'd1,3'd1,3'd1,3'd1,3'd1,3'd7});
        vecs[3] = mk(8'h41, 8'h80, 8'hE2, 1'b1, 9'd3, 2'd0, 11'h20C, 5'h02,
                     {3'd1,3'd1,3'd1,3'd1,3'd1,3'd1,3'd1,3'd7});
        vecs[4] = mk(8'hE0, 8'h80, 8'hE2, 1'b0, 9'd5, 2'd2, 11'h705, 5'h17,
                     {3'd7,3'd1,3'd1,3'd1,3'd1,3'd1,3'd1,3'd1});
        vecs[5] = mk(8'h33, 8'h0F, 8'h5A, 1'b0, 9'd6, 2'd1, 11'h19E, 5'h09,
                     {3'd5,3'd5,3'd5,3'd5,3'd2,3'd2,3'd2,3'd2});
        vecs[6] = mk(8'hC5, 8'h3C, 8'h9C, 1'b1, 9'd1, 2'd3, 11'h62E, 5'h1E,
                     {3'd6,3'd6,3'd4,3'd4,3'd4,3'd4,3'd6,3'd6});

        reset = 1'b1; ce_pix = 1'b0; hcnt = 9'd0; vcnt = 9'd0;
        hblank = 1'b0; vblank = 1'b0; vram_data = 8'h00; cram_data = 8'h00;
        prom_data = 8'h00; palette = 2'd0; flip = 1'b0;

        // Reset held with ce_pix toggling.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ce_pix = ~ce_pix;
            @(posedge clk);
            #1;
            chk("reset_rgb", rgb, 0);
            chk("reset_blank", pix_blank, 1);
        end
        @(negedge clk);
        reset = 1'b0;
        ce_pix = 1'b0;

        // Blank delay line flushes after 8 ce_pix; output follows one later.
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 8) chk("blank_flush_8", pix_blank, 1);
            if (k == 9) chk("blank_flush_9", pix_blank, 0);
        end
        chk("blank_flush_16", pix_blank, 0);

        // Table vectors, pipelined: cell i's pixels appear while cell i+1
        // is being fetched. Starting at 296 crosses the 327->0 wrap.
        hcnt = 9'd296;
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) apply(vecs[i]);
            for (int j = 0; j < 8; j++) begin
                step();
                if (i > 0) begin
                    px = vecs[i-1].exp_rgb[23 - 3*j -: 3];
                    chk($sformatf("vec%0d_px%0d", i-1, j), rgb, px);
                end
                if (i < NV && j == 3) begin
                    chk($sformatf("vec%0d_cram_addr", i), cram_addr, vecs[i].exp_cram);
                    chk($sformatf("vec%0d_prom_addr", i), prom_addr, vecs[i].exp_prom);
                end
            end
        end

        // hblank at hcnt=255 blanks rgb 8 ce_pix later.
        apply(mk(8'h00, 8'hFF, 8'hE2, 1'b0, 9'd0, 2'd0, 11'h0, 5'h0, 24'h0));
        n = (255 - int'(hcnt) + 328) % 328;
        for (int k = 0; k < n; k++) step();
        hblank = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 8) begin
                chk("hblank_pre_rgb", rgb, 7);
                chk("hblank_pre_blank", pix_blank, 0);
            end
            if (k == 9) begin
                chk("hblank_rgb", rgb, 0);
                chk("hblank_blank", pix_blank, 1);
            end
        end
        hblank = 1'b0;
        for (int k = 0; k < 16; k++) step();
        chk("hblank_release", pix_blank, 0);
        chk("hblank_release_rgb", rgb, 7);

        // ce_pix stalled mid-cell; also flip and data change during the stall.
        apply(vecs[5]);
        n = (8 - int'(hcnt[2:0])) % 8;
        for (int k = 0; k < n; k++) step();
        for (int k = 0; k < 12; k++) step();
        chk("stall_before", rgb, 5);
        vram_data = 8'hFF; cram_data = 8'h00; prom_data = 8'h00; flip = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            chk("stall_rgb", rgb, 5);
            chk("stall_blank", pix_blank, 0);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("stall_resume_px%0d", k + 4), rgb, 2);
        end

        // Reset mid-line.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_rgb", rgb, 0);
        chk("midreset_blank", pix_blank, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) step();
        chk("midreset_recover", pix_blank, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
